mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/req_slot.sv | 43 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: channel indices, FSM states,
// default wait limit and the fixed-priority winner selection.
package mem_arb_pkg;

    localparam int NUM_CH          = 3;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WAIT_CNT_W      = 8;

    typedef enum logic [1:0] {
        CH_REC  = 2'd0,
        CH_PLAY = 2'd1,
        CH_HOST = 2'd2
    } ch_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Lowest index wins: rec > play > host.
    function automatic ch_e pick_winner(input logic [NUM_CH-1:0] pend);
        if (pend[0])
            return CH_REC;
        else if (pend[1])
            return CH_PLAY;
        else
            return CH_HOST;
    endfunction

endpackage

// File: rtl/req_slot.sv
// One-deep request latch: holds a pending flag plus payload, and flags an
// overrun when a new request replaces one that was never granted.
module req_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [W-1:0] din,
    input  logic         clr,
    output logic         pending,
    output logic [W-1:0] dout,
    output logic         overrun
);

    logic         pending_reg;
    logic         overrun_reg;
    logic [W-1:0] data_reg;

    // A request in the same cycle as the grant starts a fresh entry, so it
    // only counts as an overrun when the old entry is not being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            if (req) begin
                data_reg    <= din;
                pending_reg <= 1'b1;
                if (pending_reg && !clr)
                    overrun_reg <= 1'b1;
            end else if (clr) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign pending = pending_reg;
    assign dout    = data_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Three-channel single-port memory arbiter (record write, playback read,
// host read) with fixed priority, a bounded wait for mem_ack and sticky status.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rec_req,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [DATA_W-1:0] rec_wdata,
    input  logic              play_req,
    input  logic [ADDR_W-1:0] play_addr,
    output logic [7:0]        play_data_upper,
    output logic [4:0]        play_data_lower,
    output logic              play_data_ready,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        overrun,
    output logic              timeout_err
);

    localparam int PW = ADDR_W + DATA_W;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    state_e                state_reg, state_next;
    ch_e                   active_ch_reg;
    ch_e                   win;
    logic [NUM_CH-1:0]     slot_req, slot_clr, slot_pend, slot_ovr;
    logic [PW-1:0]         slot_din  [NUM_CH];
    logic [PW-1:0]         slot_dout [NUM_CH];
    logic                  grant, wait_expired;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg;
    logic [ADDR_W-1:0]     mem_addr_reg;
    logic [DATA_W-1:0]     mem_wdata_reg;
    logic [DATA_W-1:0]     host_rdata_reg;
    logic [7:0]            play_upper_reg;
    logic [4:0]            play_lower_reg;
    logic                  timeout_reg;

    // Every slot carries {addr, wdata}; read channels leave the data field zero.
    assign slot_req                = {host_req, play_req, rec_req};
    assign slot_din[int'(CH_REC)]  = {rec_addr, rec_wdata};
    assign slot_din[int'(CH_PLAY)] = {play_addr, {DATA_W{1'b0}}};
    assign slot_din[int'(CH_HOST)] = {host_addr, {DATA_W{1'b0}}};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            req_slot #(.W(PW)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (slot_req[gi]),
                .din     (slot_din[gi]),
                .clr     (slot_clr[gi]),
                .pending (slot_pend[gi]),
                .dout    (slot_dout[gi]),
                .overrun (slot_ovr[gi])
            );
        end
    endgenerate

    assign win          = pick_winner(slot_pend);
    assign grant        = (state_reg == ST_IDLE) && (|slot_pend);
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (|slot_pend) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack)
                    state_next = ST_DONE;
                else if (wait_expired)
                    state_next = ST_IDLE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        play_data_ready = 1'b0;
        host_ready      = 1'b0;
        slot_clr        = '0;
        case (state_reg)
            ST_IDLE:  if (grant) slot_clr = NUM_CH'(1) << win;
            ST_ISSUE: begin
                mem_en = 1'b1;
                mem_we = (active_ch_reg == CH_REC);
            end
            ST_DONE: begin
                play_data_ready = (active_ch_reg == CH_PLAY);
                host_ready      = (active_ch_reg == CH_HOST);
            end
            default: ;
        endcase
    end

    // Address/data are captured at grant so they stay put through ISSUE and WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_ch_reg  <= CH_REC;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            wait_cnt_reg   <= '0;
            timeout_reg    <= 1'b0;
            play_upper_reg <= '0;
            play_lower_reg <= '0;
            host_rdata_reg <= '0;
        end else begin
            if (grant) begin
                active_ch_reg <= win;
                mem_addr_reg  <= slot_dout[win][PW-1:DATA_W];
                if (win == CH_REC)
                    mem_wdata_reg <= slot_dout[win][DATA_W-1:0];
                wait_cnt_reg  <= '0;
            end
            if (state_reg == ST_WAIT) begin
                if (mem_ack) begin
                    case (active_ch_reg)
                        CH_PLAY: begin
                            play_upper_reg <= mem_rdata[15:8];
                            play_lower_reg <= mem_rdata[7:3];
                        end
                        CH_HOST: host_rdata_reg <= mem_rdata;
                        default: ;
                    endcase
                end else if (wait_expired) begin
                    timeout_reg <= 1'b1;
                end
                if (wait_cnt_reg != '1)
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end
    end

    assign mem_addr        = mem_addr_reg;
    assign mem_wdata       = mem_wdata_reg;
    assign host_rdata      = host_rdata_reg;
    assign play_data_upper = play_upper_reg;
    assign play_data_lower = play_lower_reg;
    assign overrun         = slot_ovr;
    assign timeout_err     = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected accesses and read results are
// queued when requests are driven and checked as the memory side and channels respond.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rec_req, play_req, host_req;
    logic [AW-1:0] rec_addr, play_addr, host_addr;
    logic [DW-1:0] rec_wdata;
    logic [7:0]    play_data_upper;
    logic [4:0]    play_data_lower;
    logic          play_data_ready;
    logic [DW-1:0] host_rdata;
    logic          host_ready;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [2:0]    overrun;
    logic          timeout_err;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } rd_t;

    iss_t          iss_q[$];
    rd_t           rd_q[$];
    int            iss_cyc_q[$];
    logic [DW-1:0] mem_model [int];
    logic [DW-1:0] resp_data = '0;
    logic [DW-1:0] last_play = '0;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, en_count = 0;
    int ack_delay = 1, ack_cnt = -1;
    int issue_cyc = -1, to_cyc = -1, play_ready_cyc = -1, host_ready_cyc = -1;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rec_req         (rec_req),
        .rec_addr        (rec_addr),
        .rec_wdata       (rec_wdata),
        .play_req        (play_req),
        .play_addr       (play_addr),
        .play_data_upper (play_data_upper),
        .play_data_lower (play_data_lower),
        .play_data_ready (play_data_ready),
        .host_req        (host_req),
        .host_addr       (host_addr),
        .host_rdata      (host_rdata),
        .host_ready      (host_ready),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_read(input int ch, input logic [AW-1:0] a);
        iss_t e;
        rd_t  r;
        e.we = 1'b0; e.addr = a; e.wdata = '0;
        r.ch = ch;
        r.data = mem_model.exists(int'(a)) ? mem_model[int'(a)] : '0;
        iss_q.push_back(e);
        rd_q.push_back(r);
        if (ch == 1) last_play = r.data;
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        iss_t e;
        e.we = 1'b1; e.addr = a; e.wdata = d;
        iss_q.push_back(e);
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((iss_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL quiet_timeout: outstanding issues=%0d reads=%0d, required 0 and 0",
                     iss_q.size(), rd_q.size());
            iss_q.delete();
            rd_q.delete();
        end
        repeat (3) tick();
    endtask

    // Memory model and output monitor; samples on the falling edge.
    initial begin
        iss_t e;
        rd_t  r;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = resp_data;
                    ack_cnt   = -1;
                end
            end
            if (timeout_err === 1'b1 && to_cyc < 0) to_cyc = cyc;
            n_cmp++;
            if (mem_en !== 1'b1 && mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL mem_we_outside_issue: mem_we=%b mem_en=%b, required mem_we=0", mem_we, mem_en);
            end
            if (mem_en === 1'b1) begin
                en_count++;
                issue_cyc = cyc;
                iss_cyc_q.push_back(cyc);
                n_cmp++;
                if (iss_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected: we=%b addr=%h, required no access", mem_we, mem_addr);
                end else begin
                    e = iss_q.pop_front();
                    if ((e.we && ({mem_we, mem_addr, mem_wdata} !== {1'b1, e.addr, e.wdata})) ||
                        (!e.we && ({mem_we, mem_addr} !== {1'b0, e.addr}))) begin
                        n_fail++;
                        $display("FAIL issue: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                    end
                    if (e.we) mem_model[int'(e.addr)] = e.wdata;
                    resp_data = mem_model.exists(int'(e.addr)) ? mem_model[int'(e.addr)] : '0;
                    if (ack_delay > 0) ack_cnt = ack_delay;
                end
            end
            if (play_data_ready === 1'b1) begin
                n_cmp++;
                play_ready_cyc = cyc;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL play_ready_unexpected: upper=%h lower=%h, required no pulse",
                             play_data_upper, play_data_lower);
                end else begin
                    r = rd_q.pop_front();
                    if (r.ch != 1 || {play_data_upper, play_data_lower} !== {r.data[15:8], r.data[7:3]}) begin
                        n_fail++;
                        $display("FAIL play_data: ch1 upper=%h lower=%h, required ch%0d upper=%h lower=%h",
                                 play_data_upper, play_data_lower, r.ch, r.data[15:8], r.data[7:3]);
                    end
                end
            end
            if (host_ready === 1'b1) begin
                n_cmp++;
                host_ready_cyc = cyc;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL host_ready_unexpected: rdata=%h, required no pulse", host_rdata);
                end else begin
                    r = rd_q.pop_front();
                    if (r.ch != 2 || host_rdata !== r.data) begin
                        n_fail++;
                        $display("FAIL host_data: ch2 rdata=%h, required ch%0d rdata=%h", host_rdata, r.ch, r.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        rec_req = 1'b1; play_req = 1'b1; host_req = 1'b1;
        rec_addr = 24'h00ABCD; rec_wdata = 16'h5555; play_addr = 24'h000777; host_addr = 24'h000999;
        repeat (3) tick();
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, play_data_ready, host_ready, overrun, timeout_err,
             play_data_upper, play_data_lower, host_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b we=%b addr=%h wdata=%h ovr=%b to=%b up=%h lo=%h host=%h, required all 0",
                     mem_en, mem_we, mem_addr, mem_wdata, overrun, timeout_err, play_data_upper, play_data_lower, host_rdata);
        end
        rst_n = 1'b1;
        rec_req = 1'b0; play_req = 1'b0; host_req = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (en_count !== 0) begin
            n_fail++;
            $display("FAIL reset_drop: %0d accesses, required 0", en_count);
        end
    endtask

    task automatic test_play_read();
        int req_c;
        mem_model[int'(24'h010000)] = 16'hABF8;
        ack_delay = 1;
        exp_read(1, 24'h010000);
        play_addr = 24'h010000; play_req = 1'b1;
        req_c = cyc + 1;
        tick();
        play_req = 1'b0;
        wait_quiet(50);
        n_cmp++;
        if (play_ready_cyc - req_c !== 4) begin
            n_fail++;
            $display("FAIL play_latency: %0d cycles, required 4", play_ready_cyc - req_c);
        end
        n_cmp++;
        if ({play_data_upper, play_data_lower} !== {8'hAB, 5'h1F}) begin
            n_fail++;
            $display("FAIL play_hold: upper=%h lower=%h, required AB 1F", play_data_upper, play_data_lower);
        end
        n_cmp++;
        if (host_rdata !== '0) begin
            n_fail++;
            $display("FAIL host_untouched: rdata=%h, required 0000", host_rdata);
        end
    endtask

    task automatic test_priority();
        mem_model[int'(24'h020000)] = 16'h5A5A;
        exp_write(24'h000100, 16'h1234);
        exp_read(1, 24'h020000);
        iss_cyc_q.delete();
        rec_addr = 24'h000100; rec_wdata = 16'h1234; rec_req = 1'b1;
        play_addr = 24'h020000; play_req = 1'b1;
        tick();
        rec_req = 1'b0; play_req = 1'b0;
        wait_quiet(50);
        n_cmp++;
        if (iss_cyc_q.size() != 2 || iss_cyc_q[1] - iss_cyc_q[0] != 4) begin
            n_fail++;
            $display("FAIL priority_spacing: %0d accesses, gap %0d, required 2 accesses gap 4",
                     iss_cyc_q.size(), iss_cyc_q.size() == 2 ? iss_cyc_q[1] - iss_cyc_q[0] : -1);
        end
        n_cmp++;
        if (overrun !== 3'b000) begin
            n_fail++;
            $display("FAIL priority_overrun: overrun=%b, required 000", overrun);
        end
    endtask

    task automatic test_back_to_back();
        mem_model[int'(24'h030000)] = 16'hC3A8;
        mem_model[int'(24'h030001)] = 16'h7E10;
        exp_read(1, 24'h030000);
        exp_read(1, 24'h030001);
        play_addr = 24'h030000; play_req = 1'b1;
        tick();
        play_addr = 24'h030001;
        tick();
        play_req = 1'b0;
        wait_quiet(50);
        n_cmp++;
        if (overrun !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_overrun: overrun=%b, required 000", overrun);
        end
    endtask

    task automatic test_overrun();
        mem_model[int'(24'h040000)] = 16'h1357;
        mem_model[int'(24'h040004)] = 16'h2468;
        ack_delay = 20;
        exp_write(24'h000200, 16'hBEEF);
        exp_read(2, 24'h040004);
        rec_addr = 24'h000200; rec_wdata = 16'hBEEF; rec_req = 1'b1;
        tick();
        rec_req = 1'b0;
        repeat (2) tick();
        host_addr = 24'h040000; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        tick();
        host_addr = 24'h040004; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        wait_quiet(100);
        ack_delay = 1;
        n_cmp++;
        if (overrun !== 3'b100) begin
            n_fail++;
            $display("FAIL overrun_host: overrun=%b, required 100", overrun);
        end
        n_cmp++;
        if (host_rdata !== 16'h2468) begin
            n_fail++;
            $display("FAIL overrun_last_addr: rdata=%h, required 2468", host_rdata);
        end
        n_cmp++;
        if ({play_data_upper, play_data_lower} !== {last_play[15:8], last_play[7:3]}) begin
            n_fail++;
            $display("FAIL play_hold_after_host: upper=%h lower=%h, required %h %h",
                     play_data_upper, play_data_lower, last_play[15:8], last_play[7:3]);
        end
    endtask

    task automatic test_timeout();
        iss_t e;
        int   n = 0;
        int   req_c;
        ack_delay = 0;
        to_cyc = -1;
        e.we = 1'b0; e.addr = 24'h050000; e.wdata = '0;
        iss_q.push_back(e);
        host_addr = 24'h050000; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        while (to_cyc < 0 && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (to_cyc - issue_cyc !== 256) begin
            n_fail++;
            $display("FAIL timeout_delay: timeout_err seen %0d cycles after issue, required 256",
                     to_cyc < 0 ? -1 : to_cyc - issue_cyc);
        end
        repeat (3) tick();
        ack_delay = 1;
        mem_model[int'(24'h050010)] = 16'h0F0F;
        exp_read(2, 24'h050010);
        host_addr = 24'h050010; host_req = 1'b1;
        req_c = cyc + 1;
        tick();
        host_req = 1'b0;
        wait_quiet(50);
        n_cmp++;
        if (host_ready_cyc - req_c !== 4) begin
            n_fail++;
            $display("FAIL after_timeout_latency: %0d cycles, required 4", host_ready_cyc - req_c);
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_reset_abort();
        iss_t e;
        int   en0 = en_count;
        int   n = 0;
        ack_delay = 5;
        mem_model[int'(24'h060000)] = 16'h9999;
        e.we = 1'b0; e.addr = 24'h060000; e.wdata = '0;
        iss_q.push_back(e);
        play_addr = 24'h060000; play_req = 1'b1;
        tick();
        play_req = 1'b0;
        while (en_count == en0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, play_data_ready, host_ready, overrun, timeout_err,
             play_data_upper, play_data_lower, host_rdata} !== '0) begin
            n_fail++;
            $display("FAIL abort_reset_values: en=%b addr=%h wdata=%h ovr=%b to=%b up=%h lo=%h host=%h, required all 0",
                     mem_en, mem_addr, mem_wdata, overrun, timeout_err, play_data_upper, play_data_lower, host_rdata);
        end
        repeat (12) tick();
        n_cmp++;
        if (en_count !== en0 + 1) begin
            n_fail++;
            $display("FAIL abort_no_reissue: %0d accesses, required %0d", en_count, en0 + 1);
        end
        n_cmp++;
        if ({play_data_upper, play_data_lower, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL abort_ack_ignored: upper=%h lower=%h to=%b, required 0", play_data_upper, play_data_lower, timeout_err);
        end
        ack_delay = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_play_read();
        test_priority();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
